// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage data-memory controller: splits each 32-bit load/store into two
// 16-bit accesses on an asynchronous SRAM, each half lasting WAIT_CYCLES+1
// cycles, and holds the pipeline via ready=0 while the access is in flight.
// Optional feature macro: SRAM_LAST_READ_BUF_EN (one-entry last-read buffer).
module mem_stage_sram_ctrl #(
  parameter int WAIT_CYCLES = 1,
  parameter int BASE_ADDR   = 1024,
  parameter int SRAM_ADDR_W = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            wr_data,
  output logic [31:0]            rd_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_we_n
);

  localparam int         WORD_W    = SRAM_ADDR_W - 1;
  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t              state_r, state_s;
  logic [2:0]          cnt_r;
  logic                is_wr_r;
  logic [WORD_W-1:0]   word_r;
  logic [31:0]         wdata_r;
  logic [31:0]         rd_data_r;

  logic [31:0]         offset_s;
  logic [WORD_W-1:0]   req_word_s;
  logic                req_s;
  logic                phase_done_s;
  logic                buf_hit_s;
  logic                unused_offset_bits_s;

  // Byte address -> SRAM word index; low two bits and bits above the SRAM are dropped.
  assign offset_s             = address - 32'(BASE_ADDR);
  assign req_word_s           = offset_s[SRAM_ADDR_W:2];
  assign unused_offset_bits_s = ^{offset_s[31:SRAM_ADDR_W+1], offset_s[1:0]};
  assign req_s                = wr_en | rd_en;
  assign phase_done_s         = (cnt_r == WAIT_LAST);

`ifdef SRAM_LAST_READ_BUF_EN
  logic              buf_valid_r;
  logic [WORD_W-1:0] buf_word_r;
  logic [31:0]       buf_data_r;

  assign buf_hit_s = (state_r == IDLE) && rd_en && !wr_en && buf_valid_r &&
                     (buf_word_r == req_word_s);
  assign rd_data   = buf_hit_s ? buf_data_r : rd_data_r;

  // Last-read buffer: filled as a read completes, invalidated by any store.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid_r <= 1'b0;
      buf_word_r  <= '0;
      buf_data_r  <= 32'h0000_0000;
    end else if ((state_r == IDLE) && wr_en) begin
      buf_valid_r <= 1'b0;
    end else if ((state_r == DONE) && !is_wr_r) begin
      buf_valid_r <= 1'b1;
      buf_word_r  <= word_r;
      buf_data_r  <= rd_data_r;
    end
  end
`else
  assign buf_hit_s = 1'b0;
  assign rd_data   = rd_data_r;
`endif

  // Next-state and ready decode; ready drops in IDLE as soon as a request shows up.
  always_comb begin
    state_s = state_r;
    ready   = 1'b0;
    case (state_r)
      IDLE: begin
        if (buf_hit_s) begin
          ready   = 1'b1;
        end else if (req_s) begin
          state_s = LOW;
        end else begin
          ready   = 1'b1;
        end
      end
      LOW: begin
        if (phase_done_s) state_s = HIGH;
        else              state_s = LOW;
      end
      HIGH: begin
        if (phase_done_s) state_s = DONE;
        else              state_s = HIGH;
      end
      DONE: begin
        ready   = 1'b1;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register and wait-state phase counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_s;
      if (((state_r == LOW) || (state_r == HIGH)) && !phase_done_s) begin
        cnt_r <= cnt_r + 3'd1;
      end else begin
        cnt_r <= 3'd0;
      end
    end
  end

  // Request capture in IDLE and half-word read data capture at the end of each phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_wr_r   <= 1'b0;
      word_r    <= '0;
      wdata_r   <= 32'h0000_0000;
      rd_data_r <= 32'h0000_0000;
    end else begin
      if ((state_r == IDLE) && req_s && !buf_hit_s) begin
        is_wr_r <= wr_en;
        word_r  <= req_word_s;
        wdata_r <= wr_data;
      end
      if ((state_r == LOW) && phase_done_s && !is_wr_r) begin
        rd_data_r[15:0] <= sram_dq_in;
      end
      if ((state_r == HIGH) && phase_done_s && !is_wr_r) begin
        rd_data_r[31:16] <= sram_dq_in;
      end
    end
  end

  // SRAM pin decode from registered state only, so reset forces idle pins at once.
  always_comb begin
    sram_addr   = '0;
    sram_dq_out = 16'h0000;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    case (state_r)
      LOW: begin
        sram_addr = {word_r, 1'b0};
        if (is_wr_r) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = wdata_r[15:0];
        end else begin
          sram_we_n   = 1'b1;
        end
      end
      HIGH: begin
        sram_addr = {word_r, 1'b1};
        if (is_wr_r) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = wdata_r[31:16];
        end else begin
          sram_we_n   = 1'b1;
        end
      end
      default: begin
        sram_we_n = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl with a behavioural 16-bit SRAM.
// Optional feature macro: SRAM_LAST_READ_BUF_EN enables the buffer-hit steps.
module tb_mem_stage_sram_ctrl;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [0:63];

  mem_stage_sram_ctrl #(.WAIT_CYCLES(1), .BASE_ADDR(1024), .SRAM_ADDR_W(18)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
    .wr_data(wr_data), .rd_data(rd_data), .ready(ready), .sram_addr(sram_addr),
    .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
    .sram_we_n(sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: combinational read, write sampled on the clock edge.
  assign sram_dq_in = mem[sram_addr[5:0]];
  always @(posedge clk) begin
    if (!sram_we_n) mem[sram_addr[5:0]] <= sram_dq_out;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access; leaves the bench one cycle after DONE with inputs cleared.
  task automatic access(input string tag, input logic wr, input logic rd,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] exp_rd, input int exp_stall,
                        input logic [17:0] exp_lo);
    int stalls;
    int we_low;
    logic [17:0] a_lo;
    logic [17:0] a_hi;
    stalls = 0;
    we_low = 0;
    a_lo   = 18'h3FFFF;
    a_hi   = 18'h3FFFF;
    wr_en = wr; rd_en = rd; address = addr; wr_data = data;
    #1;
    if (exp_stall == 0) begin
      chk({tag, "_hit_addr"}, 32'(sram_addr), 32'd0);
      chk({tag, "_hit_we_n"}, 32'(sram_we_n), 32'd1);
    end
    while (!ready && stalls < 20) begin
      stalls++;
      if (sram_we_n == 1'b0) we_low++;
      if (stalls == 2) a_lo = sram_addr;
      if (stalls == 4) a_hi = sram_addr;
      @(posedge clk); #1;
    end
    chk({tag, "_stall"}, 32'(stalls), 32'(exp_stall));
    chk({tag, "_ready_done"}, 32'(ready), 32'd1);
    if (rd && !wr) chk({tag, "_rd_data"}, rd_data, exp_rd);
    if (exp_stall != 0) begin
      chk({tag, "_we_low"}, 32'(we_low), wr ? 32'd4 : 32'd0);
      chk({tag, "_addr_lo"}, 32'(a_lo), 32'(exp_lo));
      chk({tag, "_addr_hi"}, 32'(a_hi), 32'(exp_lo) + 32'd1);
    end
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    #1;
    chk({tag, "_ready_idle"}, 32'(ready), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; address = 32'd0; wr_data = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_oe", 32'(sram_dq_oe), 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", 32'(ready), 32'd1);

    // Store 0xDEADBEEF to word 0, then read it back.
    access("st1024", 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'd0, 5, 18'd0);
    chk("mem0", 32'(mem[0]), 32'h0000BEEF);
    chk("mem1", 32'(mem[1]), 32'h0000DEAD);
    access("ld1024", 1'b0, 1'b1, 32'd1024, 32'd0, 32'hDEADBEEF, 5, 18'd0);

    // Reset in the middle of a store to 1036 (word 3), while in HIGH.
    wr_en = 1'b1; address = 32'd1036; wr_data = 32'h11112222;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_rst_we_n", 32'(sram_we_n), 32'd0);
    chk("pre_rst_addr", 32'(sram_addr), 32'd7);
    rst = 1'b0;
    #1;
    chk("midrst_we_n", 32'(sram_we_n), 32'd1);
    chk("midrst_oe", 32'(sram_dq_oe), 32'd0);
    chk("midrst_addr", 32'(sram_addr), 32'd0);
    chk("midrst_dq_out", 32'(sram_dq_out), 32'd0);
    chk("midrst_rd_data", rd_data, 32'd0);
    wr_en = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", 32'(ready), 32'd1);
    chk("mem1_kept", 32'(mem[1]), 32'h0000DEAD);

    // Back-to-back store and load to 1028 (word 1, halves 2/3).
    access("st1028", 1'b1, 1'b0, 32'd1028, 32'h12345678, 32'd0, 5, 18'd2);
    access("ld1028", 1'b0, 1'b1, 32'd1028, 32'd0, 32'h12345678, 5, 18'd2);

    // Both enables high acts as a store; low address bits are ignored on the reload.
    access("both1032", 1'b1, 1'b1, 32'd1032, 32'hA5A5A5A5, 32'd0, 5, 18'd4);
    chk("mem4", 32'(mem[4]), 32'h0000A5A5);
    access("ld1032", 1'b0, 1'b1, 32'd1035, 32'd0, 32'hA5A5A5A5, 5, 18'd4);
    chk("rd_hold", rd_data, 32'hA5A5A5A5);
    access("st_hold", 1'b1, 1'b0, 32'd1040, 32'h0BADF00D, 32'd0, 5, 18'd8);
    chk("rd_hold_after_st", rd_data, 32'hA5A5A5A5);

`ifdef SRAM_LAST_READ_BUF_EN
    access("buf_miss", 1'b0, 1'b1, 32'd1024, 32'd0, 32'hDEADBEEF, 5, 18'd0);
    access("buf_hit", 1'b0, 1'b1, 32'd1024, 32'd0, 32'hDEADBEEF, 0, 18'd0);
    access("buf_st", 1'b1, 1'b0, 32'd1024, 32'hCAFEF00D, 32'd0, 5, 18'd0);
    access("buf_inval", 1'b0, 1'b1, 32'd1024, 32'd0, 32'hCAFEF00D, 5, 18'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
